// File: rtl/bank_pkg.sv
// Shared definitions for ram_bank read-side logic: default geometry and the
// reader FSM state type.
package bank_pkg;

   localparam int unsigned ADDR_BIT_DEF   = 3;
   localparam int unsigned DATA_BIT_DEF   = 16;
   localparam int unsigned MEM_HEIGHT_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/bank_reader_if.sv
// Bank pins plus the output word stream of bank_reader.
// Stream: a word transfers on a rising edge where out_valid & out_ready; once
// out_valid rises, out_data/out_last hold until that transfer.
interface bank_reader_if #(
   parameter int ADDR_BIT = 3,
   parameter int DATA_BIT = 16
);
   logic                ram_en;
   logic                ram_re;
   logic [ADDR_BIT-1:0] ram_addr_r;
   logic [DATA_BIT-1:0] ram_d_r;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_BIT-1:0] out_data;
   logic                out_last;

   modport master (
      output ram_en, ram_re, ram_addr_r,
      input  ram_d_r,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   modport slave (
      input  ram_en, ram_re, ram_addr_r,
      output ram_d_r,
      input  out_valid, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/bank_rd_fifo2.sv
// Two-entry FIFO holding {last, data} words read back from the bank.
// The head register is the output, so the word shown stays put until popped.
module bank_rd_fifo2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic [1:0]   occ
);

   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic [1:0]   occ_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         case (occ_q)
            2'd0: begin
               if (push) begin
                  head_q <= din;
                  occ_q  <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head_q <= din;
               end else if (push) begin
                  tail_q <= din;
                  occ_q  <= 2'd2;
               end else if (pop) begin
                  occ_q  <= 2'd0;
               end
            end
            2'd2: begin
               // A push with no pop cannot occur here; the issue rule prevents it.
               if (pop) begin
                  head_q <= tail_q;
                  if (push) begin
                     tail_q <= din;
                  end else begin
                     occ_q  <= 2'd1;
                  end
               end
            end
            default: occ_q <= 2'd0;
         endcase
      end
   end

   assign dout  = head_q;
   assign valid = (occ_q != 2'd0);
   assign occ   = occ_q;

endmodule

// File: rtl/bank_reader.sv
// Burst read initiator for ram_bank: walks len words from base, absorbs the
// bank's one-cycle read latency and streams the words out with a last marker.
module bank_reader
   import bank_pkg::*;
#(
   parameter int ADDR_BIT   = ADDR_BIT_DEF,
   parameter int DATA_BIT   = DATA_BIT_DEF,
   parameter int MEM_HEIGHT = MEM_HEIGHT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_BIT-1:0] base,
   input  logic [ADDR_BIT:0]   len,
   output logic                busy,
   output logic                done,
   output rd_state_t           state_dbg,
   bank_reader_if.master       bus
);

   localparam logic [ADDR_BIT:0]   LEN_MAX   = (ADDR_BIT+1)'(MEM_HEIGHT);
   localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(MEM_HEIGHT - 1);
   localparam logic [ADDR_BIT:0]   ONE_LEFT  = (ADDR_BIT+1)'(1);

   rd_state_t           state_q, state_d;
   logic [ADDR_BIT-1:0] addr_q;
   logic [ADDR_BIT:0]   rem_q;
   logic                inflight_q;
   logic                inflight_last_q;
   logic                done_q;

   logic [ADDR_BIT:0]   len_clamped;
   logic                accept;
   logic                pop;
   logic                issue;
   logic                last_issue;
   logic [2:0]          level;
   logic [1:0]          occ;
   logic                head_valid;
   logic [DATA_BIT:0]   head_word;
   logic                head_last;

   assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
   assign accept      = (state_q == IDLE) && start;
   assign pop         = head_valid && bus.out_ready;
   assign head_last   = head_word[DATA_BIT];

   // Words already owned (buffered + in flight) minus the one leaving now must
   // leave a free slot for the word this read will return.
   assign level      = {1'b0, occ} + {2'b00, inflight_q};
   assign issue      = (state_q == RUN) && (level < (3'd2 + {2'b00, pop}));
   assign last_issue = issue && (rem_q == ONE_LEFT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && (len_clamped != '0)) state_d = RUN;
         RUN:     if (last_issue) state_d = DRAIN;
         DRAIN:   if (pop && head_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         rem_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         inflight_q      <= issue;
         inflight_last_q <= last_issue;
         done_q          <= (accept && (len_clamped == '0)) ||
                            ((state_q == DRAIN) && pop && head_last);
         if (accept && (len_clamped != '0)) begin
            addr_q <= base;
            rem_q  <= len_clamped;
         end else if (issue) begin
            rem_q <= rem_q - 1'b1;
            // The final address is left on the pins once the burst has issued.
            if (!last_issue) begin
               addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            end
         end
      end
   end

   bank_rd_fifo2 #(
      .W (DATA_BIT + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q),
      .din   ({inflight_last_q, bus.ram_d_r}),
      .pop   (pop),
      .dout  (head_word),
      .valid (head_valid),
      .occ   (occ)
   );

   assign bus.ram_re     = issue;
   assign bus.ram_en     = issue;
   assign bus.ram_addr_r = addr_q;
   assign bus.out_valid  = head_valid;
   assign bus.out_data   = head_word[DATA_BIT-1:0];
   assign bus.out_last   = head_last;

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bank_reader.sv
// Bench for bank_reader: bank model, random backpressure, directed and random
// bursts checked by a scoreboard of expected words and addresses.
module tb_bank_reader;
   import bank_pkg::*;

   localparam int AB = 3;
   localparam int DB = 16;
   localparam int MH = 8;

   logic            clk;
   logic            rst;
   logic            start;
   logic [AB-1:0]   base;
   logic [AB:0]     len;
   logic            busy;
   logic            done;
   rd_state_t       state_dbg;

   bank_reader_if #(.ADDR_BIT(AB), .DATA_BIT(DB)) bus ();

   bank_reader #(
      .ADDR_BIT   (AB),
      .DATA_BIT   (DB),
      .MEM_HEIGHT (MH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base      (base),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg),
      .bus       (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- bank model ----------------
   logic [DB-1:0] mem [MH];
   initial for (int i = 0; i < MH; i++) mem[i] = 16'h1000 + 16'(i);

   always @(posedge clk) begin
      if (bus.ram_en && bus.ram_re) bus.ram_d_r <= mem[bus.ram_addr_r];
   end

   // ---------------- scoreboard state ----------------
   logic [DB:0]   exp_q[$];
   logic [AB-1:0] exp_addr_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            zero_req = 0;
   int            zero_seen = 0;
   int            issued = 0;
   int            popped = 0;
   logic          exp_done = 1'b0;
   logic          stall_prev = 1'b0;
   logic [DB:0]   prev_word = '0;
   logic          pop_now;
   logic [DB:0]   w;
   logic [AB-1:0] a;
   logic          rdy_random = 1'b0;
   logic          rdy_pat[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- ready generator ----------------
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_pat.size() > 0)  bus.out_ready = rdy_pat.pop_front();
         else if (rdy_random)     bus.out_ready = ($urandom_range(0, 2) != 0);
         else                     bus.out_ready = 1'b1;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_addr_q.delete();
         issued     = 0;
         popped     = 0;
         exp_done   = 1'b0;
         stall_prev = 1'b0;
         zero_seen  = zero_req;
      end else begin
         pop_now = bus.out_valid && bus.out_ready;
         chk("done", {31'd0, done}, {31'd0, exp_done});
         exp_done = 1'b0;
         if (zero_seen != zero_req) begin
            exp_done  = 1'b1;
            zero_seen = zero_req;
         end
         if (stall_prev) begin
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_word", 32'({bus.out_last, bus.out_data}), 32'(prev_word));
         end
         if (pop_now) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_word: got %0h expected no word at %0t",
                        {bus.out_last, bus.out_data}, $time);
            end else begin
               w = exp_q.pop_front();
               chk("stream_word", 32'({bus.out_last, bus.out_data}), 32'(w));
               if (w[DB]) exp_done = 1'b1;
            end
         end
         if (bus.ram_re || bus.ram_en) begin
            chk("ram_en_eq_re", {31'd0, bus.ram_en}, {31'd0, bus.ram_re});
         end
         if (bus.ram_re) begin
            if (exp_addr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_read: got addr %0d expected no read at %0t",
                        bus.ram_addr_r, $time);
            end else begin
               a = exp_addr_q.pop_front();
               chk("read_addr", 32'(bus.ram_addr_r), 32'(a));
            end
            chk("issue_room", {31'd0, ((issued - popped - int'(pop_now)) < 2)}, 32'd1);
         end
         issued     = issued + int'(bus.ram_re);
         popped     = popped + int'(pop_now);
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_word  = {bus.out_last, bus.out_data};
      end
   end

   // ---------------- driver tasks (entered at posedge + 1) ----------------
   task automatic start_burst(input int b, input int l);
      int n;
      int ad;
      n = (l > MH) ? MH : l;
      start = 1'b1;
      base  = AB'(b);
      len   = (AB+1)'(l);
      for (int k = 0; k < n; k++) begin
         ad = (b + k) % MH;
         exp_addr_q.push_back(AB'(ad));
         exp_q.push_back({(k == n - 1), mem[ad]});
      end
      if (n == 0) zero_req++;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic pulse_start_raw(input int b, input int l);
      start = 1'b1;
      base  = AB'(b);
      len   = (AB+1)'(l);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int  cyc;
      logic ok;
      cyc = 0;
      ok  = 1'b0;
      while (cyc < budget) begin
         if (exp_q.size() == 0 && exp_addr_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("burst_complete", {31'd0, ok}, 32'd1);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      base  = '0;
      len   = '0;
      #3;
      chk("rst_busy",      {31'd0, busy},          32'd0);
      chk("rst_done",      {31'd0, done},          32'd0);
      chk("rst_ram_en",    {31'd0, bus.ram_en},    32'd0);
      chk("rst_ram_re",    {31'd0, bus.ram_re},    32'd0);
      chk("rst_addr",      32'(bus.ram_addr_r),    32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data",  32'(bus.out_data),      32'd0);
      chk("rst_out_last",  {31'd0, bus.out_last},  32'd0);
      step(2);
      rst = 1'b0;
      step(1);

      // Basic burst, always ready
      start_burst(2, 4);
      wait_idle(40);
      // Address wrap
      start_burst(6, 5);
      wait_idle(40);
      // Backpressure pattern
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      start_burst(0, 4);
      wait_idle(60);
      // Zero-length burst
      start_burst(3, 0);
      step(2);
      chk("zero_len_busy", {31'd0, busy}, 32'd0);
      // Start while busy is ignored
      start_burst(1, 4);
      pulse_start_raw(5, 3);
      wait_idle(40);
      // Reset with a read in flight
      start_burst(1, 6);
      step(1);
      rst = 1'b1;
      #1;
      chk("arst_busy",      {31'd0, busy},          32'd0);
      chk("arst_ram_re",    {31'd0, bus.ram_re},    32'd0);
      chk("arst_ram_en",    {31'd0, bus.ram_en},    32'd0);
      chk("arst_addr",      32'(bus.ram_addr_r),    32'd0);
      chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("arst_out_data",  32'(bus.out_data),      32'd0);
      chk("arst_out_last",  {31'd0, bus.out_last},  32'd0);
      step(2);
      rst = 1'b0;
      step(1);
      start_burst(3, 5);
      wait_idle(40);
      // Length clamp
      start_burst(4, 9);
      wait_idle(60);
      // Random bursts under random backpressure, back-to-back
      rdy_random = 1'b1;
      for (int t = 0; t < 30; t++) begin
         start_burst($urandom_range(0, MH - 1), $urandom_range(0, 9));
         wait_idle(120);
      end
      rdy_random = 1'b0;
      step(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
